netwalk_dpl_header_issuer: RTL and testbench
============================================

// Module: netwalk_dpl_header_issuer
// PURPOSE
//  Transmit side of the dataplane header handshake. Buffers parsed packet headers in a FIFO and presents them one at a time on dpl_pkt_header_in/_ready.
//  Holds each header until the dataplane core returns dpl_pkt_header_accept.
//  Caps in-flight headers with a credit count, released by the dataplane's dpl_pkt_header_out_enable. Counts issued, completed and table-missed headers.
//  Sits between the header parser and the dataplane core wrapper.
// PARAMETERS
//  DPL_PKT_BIT_WIDTH    608  header width
//  FIFO_ADDR_WIDTH      4    FIFO depth = 2**FIFO_ADDR_WIDTH (16)
//  MAX_INFLIGHT         8    max headers accepted but not yet completed (1..255)
//  METER_COUNTER_SIZE   32   statistics counter width
// PORTS
//  dpl_clk                    in   1    clock
//  dpl_reset                  in   1    synchronous, active-high reset
//  hdr_in                     in   DPL_PKT_BIT_WIDTH  header from parser
//  hdr_in_valid               in   1    push request
//  hdr_in_ready               out  1    FIFO not full; push occurs when valid&ready
//  issue_enable               in   1    permits loading a new header for issue
//  dpl_pkt_header_in          out  DPL_PKT_BIT_WIDTH  header to dataplane
//  dpl_pkt_header_ready       out  1    header presented
//  dpl_pkt_header_accept      in   1    dataplane takes header
//  dpl_pkt_header_out_enable  in   1    dataplane completion pulse (returns one credit)
//  dpl_of_table_missed        in   1    qualifies completion as table miss
//  inflight                   out  8    current outstanding count
//  fifo_level                 out  FIFO_ADDR_WIDTH+1  FIFO occupancy
//  tx_count                   out  METER_COUNTER_SIZE headers accepted by dataplane
//  done_count                 out  METER_COUNTER_SIZE completions
//  miss_count                 out  METER_COUNTER_SIZE completions with table miss
//  credit_err                 out  1    sticky: completion seen with inflight==0
// BEHAVIOUR
//  Reset: FIFO emptied. FSM=IDLE. All outputs 0, except hdr_in_ready=1 in the cycle after reset releases.
//  Reset mid-transfer drops the presented header and all buffered headers. No accept is honoured during reset.
//  FIFO: push iff hdr_in_valid&hdr_in_ready. hdr_in_ready = !full (registered level).
//   A push while full is impossible by construction; there is no bypass.
//  eligible = fifo non-empty & issue_enable & (inflight < MAX_INFLIGHT).
//  The check uses the registered inflight; same-cycle completions are ignored (conservative).
//  Transfer = dpl_pkt_header_ready & dpl_pkt_header_accept at a clock edge.
//  FSM IDLE: if eligible -> load FIFO head into output register, pop, go to PRESENT.
//  FSM PRESENT: dpl_pkt_header_ready=1. dpl_pkt_header_in is held stable.
//   Ready never drops without a transfer, even if issue_enable falls.
//   On transfer: inflight+1; tx_count+1.
//    If FIFO non-empty & issue_enable & inflight+1<MAX_INFLIGHT -> load the next head and stay in PRESENT (back-to-back, 1 hdr/clk).
//    Otherwise go to IDLE; ready=0 and dpl_pkt_header_in=0 next cycle.
//  Latency: push at edge N, empty FIFO, IDLE, eligible -> ready=1 after edge N+1.
//  Completion: dpl_pkt_header_out_enable=1 -> done_count+1; if also dpl_of_table_missed -> miss_count+1.
//   inflight-1 if inflight>0. If inflight==0, inflight is unchanged and credit_err is set (sticky until reset).
//  Transfer and completion in the same cycle -> inflight unchanged.
//  Counters wrap modulo 2**METER_COUNTER_SIZE without saturation.
//  Push and pop in the same cycle -> fifo_level unchanged. Pointers wrap at depth.
// TESTING
//  1. Reset, push H=0xA5 (zero-extended), accept tied 1 -> ready high 2 cycles after push, 1-cycle pulse; tx_count=1, inflight=1.
//  2. Push 16 headers with accept=0 -> hdr_in_ready=0 at fifo_level=15 plus 1 presented.
//     Push 17 is blocked. Ready and data stay stable for 50 cycles. Then accept=1 -> 16 back-to-back transfers in order.
//  3. MAX_INFLIGHT=8, no completions, 12 queued -> exactly 8 transfers, then ready=0.
//     One out_enable pulse -> ready rises within 2 cycles, 9th transfer.
//  4. Transfer and out_enable in the same cycle at inflight=3 -> inflight stays 3.
//     out_enable with of_table_missed=1 -> done_count+1 and miss_count+1.
//  5. out_enable pulse at inflight=0 -> credit_err=1, inflight=0, done_count+1. credit_err persists until dpl_reset.
//  6. Assert dpl_reset while PRESENT with 5 queued -> next cycle ready=0, fifo_level=0, all counters 0, hdr_in_ready=1.

Source files
------------

// File: rtl/netwalk_dpl_header_issuer_if.sv
// rtl/netwalk_dpl_header_issuer_if.sv - header push and dataplane issue handshake bundle
// master drives headers in and accepts them out; slave is the issuer.
interface netwalk_dpl_header_issuer_if #(
    parameter int DPL_PKT_BIT_WIDTH = 608
);
    logic [DPL_PKT_BIT_WIDTH-1:0] hdr_in;
    logic                         hdr_in_valid;
    logic                         hdr_in_ready;
    logic [DPL_PKT_BIT_WIDTH-1:0] dpl_pkt_header_in;
    logic                         dpl_pkt_header_ready;
    logic                         dpl_pkt_header_accept;

    modport master (
        output hdr_in, hdr_in_valid, dpl_pkt_header_accept,
        input  hdr_in_ready, dpl_pkt_header_in, dpl_pkt_header_ready
    );

    modport slave (
        input  hdr_in, hdr_in_valid, dpl_pkt_header_accept,
        output hdr_in_ready, dpl_pkt_header_in, dpl_pkt_header_ready
    );
endinterface

// File: rtl/netwalk_dpl_header_issuer.sv
// rtl/netwalk_dpl_header_issuer.sv - credit-limited header FIFO feeding the dataplane core
// Headers queue in a FIFO, are presented one at a time and held until accepted.
module netwalk_dpl_header_issuer #(
    parameter int DPL_PKT_BIT_WIDTH  = 608,
    parameter int FIFO_ADDR_WIDTH    = 4,
    parameter int MAX_INFLIGHT       = 8,
    parameter int METER_COUNTER_SIZE = 32
) (
    input  logic                          dpl_clk,
    input  logic                          dpl_reset,
    netwalk_dpl_header_issuer_if.slave    bus,
    input  logic                          issue_enable,
    input  logic                          dpl_pkt_header_out_enable,
    input  logic                          dpl_of_table_missed,
    output logic [7:0]                    inflight,
    output logic [FIFO_ADDR_WIDTH:0]      fifo_level,
    output logic [METER_COUNTER_SIZE-1:0] tx_count,
    output logic [METER_COUNTER_SIZE-1:0] done_count,
    output logic [METER_COUNTER_SIZE-1:0] miss_count,
    output logic                          credit_err
);
    localparam int                          DEPTH      = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0]    FULL_LEVEL = (FIFO_ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [FIFO_ADDR_WIDTH:0]    LVL_ONE    = (FIFO_ADDR_WIDTH+1)'(1);
    localparam logic [FIFO_ADDR_WIDTH-1:0]  PTR_ONE    = FIFO_ADDR_WIDTH'(1);
    localparam logic [METER_COUNTER_SIZE-1:0] CNT_ONE  = METER_COUNTER_SIZE'(1);
    localparam logic [8:0]                  MAX_W      = 9'(MAX_INFLIGHT);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t                       state, state_nx;
    logic [DPL_PKT_BIT_WIDTH-1:0] mem [DEPTH];
    logic [DPL_PKT_BIT_WIDTH-1:0] hdr_q;
    logic [FIFO_ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic fifo_empty, fifo_full, push, load, transfer;
    logic credit_ok, credit_ok_next, ret_credit;

    // One slot is held back so the FIFO reports full at DEPTH-1 queued entries.
    assign fifo_empty     = (fifo_level == '0);
    assign fifo_full      = (fifo_level == FULL_LEVEL);
    assign push           = bus.hdr_in_valid && !fifo_full;
    assign transfer       = (state == PRESENT) && bus.dpl_pkt_header_accept;
    assign credit_ok      = {1'b0, inflight} < MAX_W;
    assign credit_ok_next = ({1'b0, inflight} + 9'd1) < MAX_W;
    assign ret_credit     = dpl_pkt_header_out_enable && (inflight != 8'd0);

    assign bus.hdr_in_ready         = !fifo_full;
    assign bus.dpl_pkt_header_ready = (state == PRESENT);
    assign bus.dpl_pkt_header_in    = hdr_q;

    always_ff @(posedge dpl_clk) begin
        if (dpl_reset) state <= IDLE;
        else           state <= state_nx;
    end

    // Credit checks use registered inflight; a same-cycle completion is not counted.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && issue_enable && credit_ok) begin
                    load     = 1'b1;
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                if (transfer) begin
                    if (!fifo_empty && issue_enable && credit_ok_next) load = 1'b1;
                    else                                               state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge dpl_clk) begin
        if (push && !dpl_reset) mem[wr_ptr] <= bus.hdr_in;
    end

    always_ff @(posedge dpl_clk) begin
        if (dpl_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            hdr_q      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (load) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, load})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            if (load)          hdr_q <= mem[rd_ptr];
            else if (transfer) hdr_q <= '0;
        end
    end

    always_ff @(posedge dpl_clk) begin
        if (dpl_reset) begin
            inflight   <= '0;
            tx_count   <= '0;
            done_count <= '0;
            miss_count <= '0;
            credit_err <= 1'b0;
        end else begin
            case ({transfer, ret_credit})
                2'b10:   inflight <= inflight + 8'd1;
                2'b01:   inflight <= inflight - 8'd1;
                default: inflight <= inflight;
            endcase
            if (transfer) tx_count <= tx_count + CNT_ONE;
            if (dpl_pkt_header_out_enable) begin
                done_count <= done_count + CNT_ONE;
                if (dpl_of_table_missed) miss_count <= miss_count + CNT_ONE;
                if (inflight == 8'd0)    credit_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_netwalk_dpl_header_issuer.sv
// tb/tb_netwalk_dpl_header_issuer.sv - directed bench for the dataplane header issuer
module tb_netwalk_dpl_header_issuer;
    localparam int W = 608;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_enable = 1'b1;
    logic        out_en = 1'b0;
    logic        missed = 1'b0;
    logic [7:0]  inflight;
    logic [4:0]  fifo_level;
    logic [31:0] tx_count, done_count, miss_count;
    logic        credit_err;
    int          total = 0;
    int          bad = 0;
    int          n;

    netwalk_dpl_header_issuer_if #(.DPL_PKT_BIT_WIDTH(W)) bus ();

    netwalk_dpl_header_issuer dut (
        .dpl_clk                   (clk),
        .dpl_reset                 (rst),
        .bus                       (bus),
        .issue_enable              (issue_enable),
        .dpl_pkt_header_out_enable (out_en),
        .dpl_of_table_missed       (missed),
        .inflight                  (inflight),
        .fifo_level                (fifo_level),
        .tx_count                  (tx_count),
        .done_count                (done_count),
        .miss_count                (miss_count),
        .credit_err                (credit_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_hdr(input int value);
        bus.hdr_in       = W'(value);
        bus.hdr_in_valid = 1'b1;
        tick();
        bus.hdr_in_valid = 1'b0;
    endtask

    initial begin
        bus.hdr_in                = '0;
        bus.hdr_in_valid          = 1'b0;
        bus.dpl_pkt_header_accept = 1'b0;
        tick();
        tick();
        check("rst_ready", bus.dpl_pkt_header_ready, 0);
        check("rst_data", bus.dpl_pkt_header_in, 0);
        check("rst_level", fifo_level, 0);
        check("rst_inflight", inflight, 0);
        check("rst_tx", tx_count, 0);
        check("rst_hdr_in_ready", bus.hdr_in_ready, 1);
        check("rst_credit_err", credit_err, 0);
        rst = 1'b0;

        // single header, accept held high: one-cycle ready pulse
        bus.dpl_pkt_header_accept = 1'b1;
        push_hdr(32'hA5);
        check("t1_ready_n1", bus.dpl_pkt_header_ready, 0);
        check("t1_level_n1", fifo_level, 1);
        tick();
        check("t1_ready_n2", bus.dpl_pkt_header_ready, 1);
        check("t1_data", bus.dpl_pkt_header_in, W'(32'hA5));
        tick();
        check("t1_ready_drop", bus.dpl_pkt_header_ready, 0);
        check("t1_data_clr", bus.dpl_pkt_header_in, 0);
        check("t1_tx", tx_count, 1);
        check("t1_inflight", inflight, 1);

        // fill to full with accept low, then hold
        bus.dpl_pkt_header_accept = 1'b0;
        for (int i = 0; i < 16; i++) push_hdr(32'h100 + i);
        check("t2_hdr_in_ready", bus.hdr_in_ready, 0);
        check("t2_level", fifo_level, 15);
        check("t2_head", bus.dpl_pkt_header_in, W'(32'h100));
        bus.hdr_in       = W'(32'h999);
        bus.hdr_in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("t2_hold_ready", bus.dpl_pkt_header_ready, 1);
            check("t2_hold_data", bus.dpl_pkt_header_in, W'(32'h100));
        end
        check("t2_blocked_level", fifo_level, 15);
        bus.hdr_in_valid = 1'b0;
        bus.dpl_pkt_header_accept = 1'b1;
        out_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("t2_b2b_ready", bus.dpl_pkt_header_ready, 1);
            check("t2_b2b_data", bus.dpl_pkt_header_in, W'(32'h100 + k));
            tick();
        end
        out_en = 1'b0;
        check("t2_end_ready", bus.dpl_pkt_header_ready, 0);
        check("t2_end_tx", tx_count, 17);
        check("t2_end_inflight", inflight, 1);
        check("t2_end_done", done_count, 16);
        check("t2_end_level", fifo_level, 0);

        // credit cap
        out_en = 1'b1;
        tick();
        out_en = 1'b0;
        check("t3_inflight0", inflight, 0);
        issue_enable = 1'b0;
        bus.dpl_pkt_header_accept = 1'b0;
        for (int i = 0; i < 12; i++) push_hdr(32'h200 + i);
        check("t3_level12", fifo_level, 12);
        issue_enable = 1'b1;
        bus.dpl_pkt_header_accept = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.dpl_pkt_header_ready) n++;
        end
        check("t3_xfers", n, 8);
        check("t3_tx", tx_count, 25);
        check("t3_inflight8", inflight, 8);
        check("t3_level4", fifo_level, 4);
        check("t3_stalled", bus.dpl_pkt_header_ready, 0);
        out_en = 1'b1;
        tick();
        out_en = 1'b0;
        check("t3_inflight7", inflight, 7);
        tick();
        check("t3_resume_ready", bus.dpl_pkt_header_ready, 1);
        check("t3_resume_data", bus.dpl_pkt_header_in, W'(32'h208));
        tick();
        check("t3_tx9", tx_count, 26);
        check("t3_inflight_back8", inflight, 8);
        check("t3_ready_low", bus.dpl_pkt_header_ready, 0);

        // transfer and completion together, then table miss
        issue_enable = 1'b0;
        bus.dpl_pkt_header_accept = 1'b0;
        out_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_en = 1'b0;
        check("t4_inflight3", inflight, 3);
        issue_enable = 1'b1;
        tick();
        check("t4_data", bus.dpl_pkt_header_in, W'(32'h209));
        bus.dpl_pkt_header_accept = 1'b1;
        out_en = 1'b1;
        tick();
        check("t4_same_cycle_inflight", inflight, 3);
        check("t4_tx", tx_count, 27);
        check("t4_done", done_count, 24);
        check("t4_next_data", bus.dpl_pkt_header_in, W'(32'h20A));
        bus.dpl_pkt_header_accept = 1'b0;
        missed = 1'b1;
        tick();
        out_en = 1'b0;
        missed = 1'b0;
        check("t4_miss", miss_count, 1);
        check("t4_done_miss", done_count, 25);
        check("t4_inflight2", inflight, 2);
        check("t4_held_data", bus.dpl_pkt_header_in, W'(32'h20A));
        bus.dpl_pkt_header_accept = 1'b1;
        tick();
        tick();
        bus.dpl_pkt_header_accept = 1'b0;
        check("t4_drain_tx", tx_count, 29);
        check("t4_drain_inflight", inflight, 4);
        check("t4_drain_ready", bus.dpl_pkt_header_ready, 0);
        out_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // completion with nothing outstanding
        check("t5_pre_err", credit_err, 0);
        tick();
        out_en = 1'b0;
        check("t5_err", credit_err, 1);
        check("t5_inflight", inflight, 0);
        check("t5_done", done_count, 30);
        for (int i = 0; i < 3; i++) tick();
        check("t5_err_sticky", credit_err, 1);

        // reset while presenting with queued headers
        for (int i = 0; i < 6; i++) push_hdr(32'h300 + i);
        check("t6_ready", bus.dpl_pkt_header_ready, 1);
        check("t6_level", fifo_level, 5);
        rst = 1'b1;
        bus.dpl_pkt_header_accept = 1'b1;
        tick();
        check("t6_rst_ready", bus.dpl_pkt_header_ready, 0);
        check("t6_rst_data", bus.dpl_pkt_header_in, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_tx", tx_count, 0);
        check("t6_rst_done", done_count, 0);
        check("t6_rst_miss", miss_count, 0);
        check("t6_rst_inflight", inflight, 0);
        check("t6_rst_err", credit_err, 0);
        check("t6_rst_hdr_in_ready", bus.hdr_in_ready, 1);
        rst = 1'b0;
        tick();
        check("t6_post_ready", bus.dpl_pkt_header_ready, 0);
        check("t6_post_tx", tx_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
